dcache_wb: RTL and testbench

DCACHE_WB -- requirements
Module: dcache_wb

---
 rtl/dcache_pkg.sv | 30 +++
 rtl/dcache_wb.sv | 134 +++++++++++++
 tb/tb_dcache_wb.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the write-back data cache: FSM state encoding and
// address field-width helpers derived from the line and word counts.
package dcache_pkg;

    // Byte offset inside a 32-bit word
    localparam int unsigned OFFSET_W  = 2;
    localparam int unsigned DEF_LINES = 4;
    localparam int unsigned DEF_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_REFILL    = 2'd2
    } state_e;

    function automatic int unsigned index_width(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned word_width(input int unsigned words);
        return $clog2(words);
    endfunction

    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned lines,
                                              input int unsigned words);
        return addr_w - index_width(lines) - word_width(words) - OFFSET_W;
    endfunction

endpackage

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   addr, data            - CPU word address and store data
//   is_load, is_store     - CPU request strobes (held while stall=1)
//   out, stall            - load data (combinational on hit), CPU freeze
//   mem_req, mem_we       - memory word transfer request / direction
//   mem_addr, mem_wdata   - memory word address and write-back data
//   mem_rdata, mem_ack    - refill data and per-word acknowledge
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LINES  = 4,
    parameter int unsigned WORDS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              is_load,
    input  logic              is_store,
    output logic [DATA_W-1:0] out,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int unsigned IDX_W  = index_width(LINES);
    localparam int unsigned WORD_W = word_width(WORDS);
    localparam int unsigned TAG_W  = tag_width(ADDR_W, LINES, WORDS);

    // Address fields
    logic [WORD_W-1:0] word;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              unused_offset;

    assign word          = addr[OFFSET_W +: WORD_W];
    assign idx           = addr[OFFSET_W + WORD_W +: IDX_W];
    assign tag           = addr[ADDR_W-1 -: TAG_W];
    assign unused_offset = ^addr[OFFSET_W-1:0];

    // Storage: data/tag arrays are not reset, valid/dirty are
    logic [DATA_W-1:0] data_mem [LINES][WORDS];
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] cnt_q;
    logic              req, hit, cnt_last;

    assign req      = is_load | is_store;
    assign hit      = req && valid_q[idx] && (tag_mem[idx] == tag);
    assign cnt_last = (cnt_q == WORD_W'(WORDS - 1));

    // Gate with hit so out is never driven from an unwritten array entry
    assign out = hit ? data_mem[idx][word] : '0;

    // Next-state and memory-side outputs
    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (req && !hit) begin
                    stall   = 1'b1;
                    state_d = (valid_q[idx] && dirty_q[idx]) ? ST_WRITEBACK : ST_REFILL;
                end
            end
            ST_WRITEBACK: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_mem[idx], idx, cnt_q, OFFSET_W'(0)};
                mem_wdata = data_mem[idx][cnt_q];
                if (mem_ack && cnt_last) state_d = ST_REFILL;
            end
            ST_REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {tag, idx, cnt_q, OFFSET_W'(0)};
                if (mem_ack && cnt_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, word counter and line status bits
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE) begin
                cnt_q <= '0;
                if (hit && is_store) dirty_q[idx] <= 1'b1;
            end else if (mem_ack) begin
                // Wraps to 0 after the last word of each burst
                cnt_q <= cnt_q + WORD_W'(1);
                if (state_q == ST_REFILL && cnt_last) begin
                    valid_q[idx] <= 1'b1;
                    dirty_q[idx] <= 1'b0;
                end
            end
        end
    end

    // Data and tag array writes: refill words, then store hits
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_REFILL && mem_ack) begin
                data_mem[idx][cnt_q] <= mem_rdata;
                if (cnt_last) tag_mem[idx] <= tag;
            end else if (state_q == ST_IDLE && hit && is_store) begin
                data_mem[idx][word] <= data;
            end
        end
    end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb: a small memory model answers transfers,
// expected memory transactions are queued when a request is issued and
// compared as the cache performs them.
module tb_dcache_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, data;
    logic        is_load, is_store;
    logic [31:0] out;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
    } xact_t;

    xact_t exp_q[$];

    // Backing memory: written words override a fixed default pattern
    bit    [31:0] wr_data [256];
    bit           wr_flag [256];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        if (a >= 32'h40 && a <= 32'h4C) return ((a - 32'h40) >> 2) + 32'd1;
        return 32'hD000_0000 | a;
    endfunction

    assign mem_rdata = wr_flag[mem_addr[9:2]] ? wr_data[mem_addr[9:2]] : dflt(mem_addr);

    always @(posedge clk) begin
        if (mem_req && mem_ack && mem_we) begin
            wr_data[mem_addr[9:2]] <= mem_wdata;
            wr_flag[mem_addr[9:2]] <= 1'b1;
        end
    end

    always #5 clk = ~clk;

    dcache_wb dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .data     (data),
        .is_load  (is_load),
        .is_store (is_store),
        .out      (out),
        .stall    (stall),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;
    bit          toggle_ack = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_refill(input logic [31:0] base);
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, base + 32'(4 * i), 32'h0});
    endtask

    task automatic push_wb(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({1'b1, a, d});
    endtask

    // Called at the negedge: score a completed word and check address hold
    task automatic mon_mem();
        xact_t x;
        if (prev_wait && mem_req) check("mem_addr_hold", mem_addr, prev_addr);
        if (mem_req && mem_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_xact", mem_addr, 32'hFFFF_FFFF);
            end else begin
                x = exp_q.pop_front();
                check("mem_we", 32'(mem_we), 32'(x.we));
                check("mem_addr", mem_addr, x.a);
                if (x.we) check("mem_wdata", mem_wdata, x.d);
            end
        end
        prev_wait = mem_req && !mem_ack;
        prev_addr = mem_addr;
    endtask

    // Issue one CPU request and hold it until stall drops
    task automatic cpu_op(input string tag, input logic ld, input logic st,
                          input logic [31:0] a, input logic [31:0] d,
                          input int exp_stall, input bit chk_out,
                          input logic [31:0] exp_out);
        int stalls = 0;
        bit done = 1'b0;
        is_load = ld; is_store = st; addr = a; data = d;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            mon_mem();
            if (stall) stalls++;
            else begin
                done = 1'b1;
                if (chk_out) check({tag, "_out"}, out, exp_out);
            end
            @(posedge clk);
            #1;
            if (toggle_ack) mem_ack = ~mem_ack;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        is_load = 1'b0; is_store = 1'b0;
    endtask

    initial begin
        reset = 1'b1; is_load = 1'b0; is_store = 1'b0;
        addr = '0; data = '0; mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_out_known", 32'(^out === 1'bx), 32'd0);
        @(posedge clk); #1;

        // Clean miss then hit
        push_refill(32'h40);
        cpu_op("load40", 1'b1, 1'b0, 32'h40, '0, 5, 1'b1, 32'd1);
        cpu_op("load48", 1'b1, 1'b0, 32'h48, '0, 0, 1'b1, 32'd3);

        // Store hit, then conflicting load forces write-back
        cpu_op("store44", 1'b0, 1'b1, 32'h44, 32'hAA, 0, 1'b0, '0);
        push_wb(32'h40, 32'd1); push_wb(32'h44, 32'hAA);
        push_wb(32'h48, 32'd3); push_wb(32'h4C, 32'd4);
        push_refill(32'h140);
        cpu_op("load144", 1'b1, 1'b0, 32'h144, '0, 9, 1'b1, dflt(32'h144));

        // Store miss allocates the line, then hits without traffic
        push_refill(32'h80);
        cpu_op("store80", 1'b0, 1'b1, 32'h80, 32'h55, 5, 1'b0, '0);
        cpu_op("load80", 1'b1, 1'b0, 32'h80, '0, 0, 1'b1, 32'h55);

        // Evict dirty 0x80 line; refilled 0x44 must show written-back 0xAA
        push_wb(32'h80, 32'h55); push_wb(32'h84, dflt(32'h84));
        push_wb(32'h88, dflt(32'h88)); push_wb(32'h8C, dflt(32'h8C));
        push_refill(32'h40);
        cpu_op("load44", 1'b1, 1'b0, 32'h44, '0, 9, 1'b1, 32'hAA);

        // Acknowledge every other refill cycle
        push_refill(32'hC0);
        mem_ack = 1'b0; toggle_ack = 1'b1;
        cpu_op("loadC4_toggle", 1'b1, 1'b0, 32'hC4, '0, 8, 1'b1, dflt(32'hC4));
        toggle_ack = 1'b0; mem_ack = 1'b1;

        // Reset during the second refill cycle aborts the refill
        exp_q.push_back({1'b0, 32'h100, 32'h0});
        exp_q.push_back({1'b0, 32'h104, 32'h0});
        is_load = 1'b1; addr = 32'h100;
        @(negedge clk); mon_mem(); check("abort_idle_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        @(negedge clk); mon_mem();
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk); mon_mem(); check("abort_refill2_req", 32'(mem_req), 32'd1);
        @(posedge clk); #1 reset = 1'b0; is_load = 1'b0;
        @(negedge clk); mon_mem();
        check("abort_mem_req", 32'(mem_req), 32'd0);
        check("abort_stall", 32'(stall), 32'd0);
        check("abort_queue_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        push_refill(32'h100);
        cpu_op("reload100", 1'b1, 1'b0, 32'h100, '0, 5, 1'b1, dflt(32'h100));

        // Load and store together behave as a store
        cpu_op("ldst100", 1'b1, 1'b1, 32'h100, 32'h77, 0, 1'b0, '0);
        cpu_op("load100", 1'b1, 1'b0, 32'h100, '0, 0, 1'b1, 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
